// File: rtl/configs.sv
// rtl/configs.sv - shared decoder datapath configuration constants
package configs;
  localparam int LiftingFactor = 8;
  localparam int ShiftWidth    = 3;
endpackage

// File: rtl/qsn_inverse.sv
// rtl/qsn_inverse.sv - inverse quasi-cyclic shift stage with queued shift values
module qsn_inverse #(
  parameter int LiftingFactor = configs::LiftingFactor,
  parameter int ShiftWidth    = configs::ShiftWidth,
  parameter int Depth         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       shift_push_i,
  input  logic [ShiftWidth-1:0]      shift_i,
  output logic                       shift_full_o,
  output logic                       shift_err_o,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [LiftingFactor-1:0]   in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [LiftingFactor-1:0]   out_data_o,
  output logic [$clog2(Depth):0]     level_o
);

  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;
  localparam logic [ShiftWidth:0] ZLimit = (ShiftWidth + 1)'(LiftingFactor);

  logic [ShiftWidth-1:0]    mem [Depth];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [LW-1:0]            level;
  logic                     pop;
  logic                     push;
  logic                     shift_ok;
  logic                     has_room;
  logic [ShiftWidth-1:0]    head;
  logic [LiftingFactor-1:0] rotated;

  assign level_o      = level;
  assign shift_full_o = (level == LW'(Depth));
  assign in_ready_o   = (level != '0) && (!out_valid_o || out_ready_i);
  assign pop          = in_valid_i && in_ready_o;
  assign shift_ok     = shift_push_i && ({1'b0, shift_i} < ZLimit);
  assign has_room     = (level != LW'(Depth)) || pop;
  assign push         = shift_ok && has_room;

  // Left rotation by s: out[j] = in[(j-s) mod Z], taken from the upper half of a doubled word.
  assign head    = mem[rd_ptr];
  assign rotated = LiftingFactor'(({in_data_i, in_data_i} << head) >> LiftingFactor);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      shift_err_o <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
      if (shift_push_i && !push) shift_err_o <= 1'b1;
      if (pop) begin
        out_valid_o <= 1'b1;
        out_data_o  <= rotated;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qsn_inverse.sv
// tb/tb_qsn_inverse.sv - randomized self-checking bench for qsn_inverse
module tb_qsn_inverse;
  localparam int Z  = 8;
  localparam int SW = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          shift_push_i = 1'b0;
  logic [SW-1:0] shift_i = '0;
  logic          shift_full_o;
  logic          shift_err_o;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [Z-1:0]  in_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [Z-1:0]  out_data_o;
  logic [2:0]    level_o;

  int checks = 0;
  int errors = 0;

  int       q[$];
  bit       m_ov;
  logic [7:0] m_od;
  bit       m_err;

  qsn_inverse #(.LiftingFactor(Z), .ShiftWidth(SW), .Depth(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .shift_push_i(shift_push_i), .shift_i(shift_i),
    .shift_full_o(shift_full_o), .shift_err_o(shift_err_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .level_o(level_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] inv_rot(input logic [7:0] x, input int s);
    logic [7:0] r;
    for (int j = 0; j < Z; j++) r[j] = x[(j - s + Z) % Z];
    return r;
  endfunction

  function automatic logic [7:0] fwd_rot(input logic [7:0] x, input int s);
    logic [7:0] r;
    for (int i = 0; i < Z; i++) r[i] = x[(i + s) % Z];
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_err", 32'(shift_err_o), 32'd0);
    check("rst_full", 32'(shift_full_o), 32'd0);
    check("rst_out_data", 32'(out_data_o), 32'd0);
    check("rst_in_ready", 32'(in_ready_o), 32'd0);
    q.delete();
    m_ov = 1'b0;
    m_od = '0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cycle(input bit p, input int sh, input bit iv, input logic [7:0] d, input bit ordy);
    bit exp_rdy;
    bit pop;
    bit pok;
    logic [7:0] r;
    shift_push_i = p;
    shift_i      = SW'(sh);
    in_valid_i   = iv;
    in_data_i    = d;
    out_ready_i  = ordy;
    #1;
    exp_rdy = (q.size() > 0) && (!m_ov || ordy);
    check("in_ready", 32'(in_ready_o), 32'(exp_rdy));
    pop = iv && exp_rdy;
    r = '0;
    if (pop) r = inv_rot(d, q[0]);
    pok = p && (sh < Z) && ((q.size() < D) || pop);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q.pop_front());
      m_ov = 1'b1;
      m_od = r;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (pok) q.push_back(sh);
    if (p && !pok) m_err = 1'b1;
    check("out_valid", 32'(out_valid_o), 32'(m_ov));
    check("out_data", 32'(out_data_o), 32'(m_od));
    check("level", 32'(level_o), 32'(q.size()));
    check("full", 32'(shift_full_o), 32'(q.size() == D));
    check("err", 32'(shift_err_o), 32'(m_err));
    shift_push_i = 1'b0;
    in_valid_i   = 1'b0;
  endtask

  initial begin
    logic [7:0] dd;
    logic [7:0] held;
    #1;
    out_ready_i = 1'b1;
    do_reset();

    // basic single block
    cycle(1, 3, 0, 8'h00, 1);
    cycle(0, 0, 1, 8'h01, 1);
    check("t1_data", 32'(out_data_o), 32'h08);
    check("t1_level", 32'(level_o), 32'd0);
    cycle(0, 0, 0, 8'h00, 1);

    // four queued shifts, back-to-back blocks
    cycle(1, 0, 0, 8'h00, 1);
    cycle(1, 1, 0, 8'h00, 1);
    cycle(1, 7, 0, 8'h00, 1);
    check("t2_not_full", 32'(shift_full_o), 32'd0);
    cycle(1, 5, 0, 8'h00, 1);
    check("t2_full", 32'(shift_full_o), 32'd1);
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 8'hA5, 1);
    check("t2_last", 32'(out_data_o), 32'(inv_rot(8'hA5, 5)));
    cycle(0, 0, 0, 8'h00, 1);

    // forward then inverse is identity
    for (int s = 0; s < Z; s++) begin
      dd = 8'($urandom);
      cycle(1, s, 0, 8'h00, 1);
      cycle(0, 0, 1, fwd_rot(dd, s), 1);
      check("t3_roundtrip", 32'(out_data_o), 32'(dd));
    end

    // overflow
    for (int k = 0; k < 4; k++) cycle(1, int'($urandom_range(0, 7)), 0, 8'h00, 1);
    cycle(1, 2, 0, 8'h00, 1);
    check("t4_err", 32'(shift_err_o), 32'd1);
    check("t4_level", 32'(level_o), 32'd4);
    cycle(0, 0, 0, 8'h00, 1);
    check("t4_err_sticky", 32'(shift_err_o), 32'd1);
    cycle(1, 2, 1, 8'($urandom), 1);
    check("t4_pushpop_level", 32'(level_o), 32'd4);
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 8'($urandom), 1);

    // out-of-range shift and empty-FIFO hold-off
    do_reset();
    cycle(1, 9, 0, 8'h00, 1);
    check("t5_err", 32'(shift_err_o), 32'd1);
    check("t5_level", 32'(level_o), 32'd0);
    cycle(0, 0, 1, 8'h5A, 1);
    check("t5_no_out", 32'(out_valid_o), 32'd0);

    // backpressure then asynchronous reset mid-stream
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1, int'($urandom_range(0, 7)), 0, 8'h00, 1);
    dd = 8'($urandom);
    held = inv_rot(dd, q[0]);
    cycle(0, 0, 1, dd, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 1, 8'($urandom), 0);
      check("t6_hold", 32'(out_data_o), 32'(held));
    end
    cycle(1, 9, 0, 8'h00, 0);
    do_reset();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom % 4) != 0,
            (($urandom % 16) < 2) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7)),
            ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);
      if (k == 200) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
